// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 round-robin / direct multiplexer.
package mux_pkg;

  localparam logic MODE_DIRECT  = 1'b0;
  localparam logic MODE_RR      = 1'b1;
  localparam int   MAX_CHANNELS = 8;

  // Index width needed to address v channels; never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_rr_n_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, scanning upward
// with wrap-around.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NChannels = 4,
  parameter int IdxW      = clog2(NChannels)
) (
  input  logic [NChannels-1:0] req,
  input  logic [IdxW-1:0]      ptr,
  output logic [NChannels-1:0] grant,
  output logic [IdxW-1:0]      idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NChannels; k++) begin
      for (int j = 0; j < NChannels; j++) begin
        if (!found && (j == (int'(ptr) + k) % NChannels) && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IdxW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_n.sv
// Registered N-to-1 mux with direct or round-robin selection and valid/ready output.
// Optional MUX_RR_XFER_COUNT_EN adds a saturating count of accepted output words.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int NBits     = 32,
  parameter int NChannels = 4,
  parameter int SelBits   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NChannels*NBits-1:0] Data,
  input  logic [NChannels-1:0]     req,
  input  logic [SelBits-1:0]       Selector,
  input  logic                     Mode,
  input  logic                     out_ready,
  output logic [NChannels-1:0]     in_ack,
  output logic [NBits-1:0]         OUT,
  output logic                     out_valid,
  output logic                     sel_error
`ifdef MUX_RR_XFER_COUNT_EN
  ,
  output logic [15:0]              xfer_count
`endif
);

  localparam int IdxW = clog2(NChannels);
  localparam int SelN = 1 << SelBits;

  generate
    if (NChannels < 2 || NChannels > MAX_CHANNELS)
      $error("mux_rr_n: NChannels must be in 2..%0d", MAX_CHANNELS);
    if (SelN < NChannels)
      $error("mux_rr_n: SelBits too narrow for NChannels");
  endgenerate

  logic [IdxW-1:0]      ptr_p1;
  logic [NBits-1:0]     out_p1;
  logic                 vld_p1;
  logic                 err_p1;

  logic                 load;
  logic                 sel_ok;
  logic [SelN-1:0]      req_pad;
  logic                 dir_hit;
  logic [NChannels-1:0] dir_grant;
  logic [NChannels-1:0] rr_grant;
  logic [IdxW-1:0]      rr_idx;
  logic [NChannels-1:0] win_grant;
  logic                 has_win;
  logic [NBits-1:0]     sel_data;

  rr_arbiter #(
    .NChannels (NChannels),
    .IdxW      (IdxW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_p1),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // Stage p0: winner selection and handshake, all combinational.
  assign load    = !vld_p1 || out_ready;
  assign sel_ok  = int'(Selector) < NChannels;
  assign req_pad = SelN'(req);
  assign dir_hit = sel_ok && req_pad[Selector];

  always_comb begin
    dir_grant = '0;
    for (int j = 0; j < NChannels; j++) begin
      dir_grant[j] = dir_hit && (int'(Selector) == j);
    end
  end

  assign win_grant = (Mode == MODE_RR) ? rr_grant : dir_grant;
  assign has_win   = |win_grant;

  // Held low during reset so no channel believes it was consumed.
  assign in_ack = (reset && load) ? win_grant : '0;

  always_comb begin
    sel_data = '0;
    for (int j = 0; j < NChannels; j++) begin
      if (win_grant[j]) sel_data = sel_data | Data[j*NBits +: NBits];
    end
  end

  // Stage p1: output register, pointer and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      ptr_p1 <= IdxW'(NChannels - 1);
    end else begin
      err_p1 <= (Mode == MODE_DIRECT) && !sel_ok && (|req);
      if (load) begin
        vld_p1 <= has_win;
        if (has_win) out_p1 <= sel_data;
        if (has_win && Mode == MODE_RR) ptr_p1 <= rr_idx;
      end
    end
  end

  assign OUT       = out_p1;
  assign out_valid = vld_p1;
  assign sel_error = err_p1;

`ifdef MUX_RR_XFER_COUNT_EN
  logic [15:0] cnt_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p1 <= '0;
    end else if (vld_p1 && out_ready && cnt_p1 != 16'hFFFF) begin
      cnt_p1 <= cnt_p1 + 16'd1;
    end
  end

  assign xfer_count = cnt_p1;
`endif

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: directed vector table, async reset sequence, then random
// traffic checked against a behavioural model.
module tb_mux_rr_n;

  localparam int N  = 4;
  localparam int NB = 32;
  localparam int SB = 3;
  localparam logic [31:0] D0 = 32'h0000_0011;
  localparam logic [31:0] D1 = 32'hCAFE_0001;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h3333_3333;

  logic            clk = 1'b0;
  logic            reset;
  logic [NB-1:0]   d [N];
  logic [N*NB-1:0] data_bus;
  logic [N-1:0]    req;
  logic [SB-1:0]   Selector;
  logic            Mode;
  logic            out_ready;
  logic [N-1:0]    in_ack;
  logic [NB-1:0]   OUT;
  logic            out_valid;
  logic            sel_error;
`ifdef MUX_RR_XFER_COUNT_EN
  logic [15:0]     xfer_count;
`endif

  int total = 0;
  int bad   = 0;

  assign data_bus = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  mux_rr_n #(.NBits(NB), .NChannels(N), .SelBits(SB)) dut (
    .clk       (clk),
    .reset     (reset),
    .Data      (data_bus),
    .req       (req),
    .Selector  (Selector),
    .Mode      (Mode),
    .out_ready (out_ready),
    .in_ack    (in_ack),
    .OUT       (OUT),
    .out_valid (out_valid),
    .sel_error (sel_error)
`ifdef MUX_RR_XFER_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Winner by the rules: direct = Selector if in range and requesting;
  // round-robin = first requester after ptr, wrapping. -1 means none.
  function automatic int mwin(input logic mode, input int sel, input logic [N-1:0] r, input int ptr);
    if (mode == 1'b0) begin
      if (sel < N && ((r >> sel) & 4'd1) != 4'd0) return sel;
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (((r >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  typedef struct {
    logic        mode;
    int          sel;
    logic [3:0]  rq;
    logic        rdy;
    logic [3:0]  ack;
    logic [31:0] out;
    logic        vld;
    logic        err;
  } vec_t;

  vec_t vt [25];

  // Model state for the random phase.
  int          m_ptr;
  logic [31:0] m_out;
  logic        m_vld;
  logic        m_err;
  int          m_cnt;

  initial begin
    vt[0]  = '{1'b0, 2, 4'b0100, 1'b1, 4'b0100, D2, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 5, 4'b1111, 1'b1, 4'b0000, D2, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 1, 4'b1111, 1'b1, 4'b0010, D1, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 0, 4'b1111, 1'b1, 4'b0001, D0, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 0, 4'b1111, 1'b1, 4'b0010, D1, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 0, 4'b1111, 1'b1, 4'b0100, D2, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 0, 4'b1111, 1'b1, 4'b1000, D3, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 0, 4'b1111, 1'b1, 4'b0001, D0, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 0, 4'b1111, 1'b1, 4'b0010, D1, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 0, 4'b1010, 1'b1, 4'b1000, D3, 1'b1, 1'b0};
    vt[10] = '{1'b1, 0, 4'b1010, 1'b1, 4'b0010, D1, 1'b1, 1'b0};
    vt[11] = '{1'b1, 0, 4'b1010, 1'b1, 4'b1000, D3, 1'b1, 1'b0};
    vt[12] = '{1'b1, 0, 4'b1010, 1'b1, 4'b0010, D1, 1'b1, 1'b0};
    vt[13] = '{1'b1, 0, 4'b0001, 1'b1, 4'b0001, D0, 1'b1, 1'b0};
    vt[14] = '{1'b1, 0, 4'b1111, 1'b0, 4'b0000, D0, 1'b1, 1'b0};
    vt[15] = '{1'b1, 0, 4'b1111, 1'b0, 4'b0000, D0, 1'b1, 1'b0};
    vt[16] = '{1'b0, 5, 4'b1111, 1'b0, 4'b0000, D0, 1'b1, 1'b1};
    vt[17] = '{1'b1, 0, 4'b1111, 1'b1, 4'b0010, D1, 1'b1, 1'b0};
    vt[18] = '{1'b1, 0, 4'b0000, 1'b1, 4'b0000, D1, 1'b0, 1'b0};
    vt[19] = '{1'b1, 0, 4'b0000, 1'b0, 4'b0000, D1, 1'b0, 1'b0};
    vt[20] = '{1'b1, 0, 4'b0100, 1'b0, 4'b0100, D2, 1'b1, 1'b0};
    vt[21] = '{1'b0, 7, 4'b0000, 1'b1, 4'b0000, D2, 1'b0, 1'b0};
    vt[22] = '{1'b0, 3, 4'b1000, 1'b1, 4'b1000, D3, 1'b1, 1'b0};
    vt[23] = '{1'b1, 0, 4'b1001, 1'b1, 4'b1000, D3, 1'b1, 1'b0};
    vt[24] = '{1'b1, 0, 4'b1001, 1'b1, 4'b0001, D0, 1'b1, 1'b0};

    d[0] = D0; d[1] = D1; d[2] = D2; d[3] = D3;
    reset = 1'b0; Mode = 1'b0; Selector = '0; req = 4'b1111; out_ready = 1'b1;

    // Reset state, with requests present to show no ack leaks out.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", OUT, 32'h0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(sel_error), 32'd0);
    chk("rst_ack", 32'(in_ack), 32'd0);
`ifdef MUX_RR_XFER_COUNT_EN
    chk("rst_cnt", 32'(xfer_count), 32'd0);
`endif
    req = '0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: one row per clock.
    for (int i = 0; i < 25; i++) begin
      Mode = vt[i].mode; Selector = SB'(vt[i].sel); req = vt[i].rq; out_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d_ack", i), 32'(in_ack), 32'(vt[i].ack));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out", i), OUT, vt[i].out);
      chk($sformatf("vec%0d_vld", i), 32'(out_valid), 32'(vt[i].vld));
      chk($sformatf("vec%0d_err", i), 32'(sel_error), 32'(vt[i].err));
    end

    // Asynchronous reset mid-stream (out_valid=1 here), away from any edge.
    Mode = 1'b1; req = 4'b1111; out_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_out", OUT, 32'h0);
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_ack", 32'(in_ack), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_vld", 32'(out_valid), 32'd0);
`ifdef MUX_RR_XFER_COUNT_EN
    chk("arst_cnt", 32'(xfer_count), 32'd0);
`endif
    reset = 1'b1;
    #1;
    chk("arst_first_ack", 32'(in_ack), 32'b0001);
    @(posedge clk);
    #1;
    chk("arst_first_out", OUT, D0);
    chk("arst_first_vld", 32'(out_valid), 32'd1);

    m_ptr = 0; m_out = D0; m_vld = 1'b1; m_err = 1'b0; m_cnt = 0;

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int   sel, w;
      logic ld;
      logic [3:0] eack;
      sel = int'($urandom_range(0, 7));
      Mode = ($urandom_range(0, 3) != 0);
      Selector = SB'(sel);
      req = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) d[c] = $urandom;
      #1;
      w = mwin(Mode, sel, req, m_ptr);
      ld = !m_vld || out_ready;
      eack = (ld && w >= 0) ? 4'(1 << w) : 4'b0000;
      chk("rnd_ack", 32'(in_ack), 32'(eack));
      // Next state from the rules, using pre-edge values.
      m_err = (Mode == 1'b0) && (sel >= N) && (req != 4'b0000);
      if (m_vld && out_ready && m_cnt < 65535) m_cnt++;
      if (ld) begin
        m_vld = (w >= 0);
        if (w >= 0) begin
          m_out = d[w];
          if (Mode) m_ptr = w;
        end
      end
      @(posedge clk);
      #1;
      chk("rnd_out", OUT, m_out);
      chk("rnd_vld", 32'(out_valid), 32'(m_vld));
      chk("rnd_err", 32'(sel_error), 32'(m_err));
`ifdef MUX_RR_XFER_COUNT_EN
      chk("rnd_cnt", 32'(xfer_count), 32'(m_cnt));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
